// File: rtl/layer_compositor_if.sv
// layer_compositor_if
//   Groups the pixel-job handshake and the composited-color handshake of
//   layer_compositor.
//   Pixel job  : i_pix_valid / o_pix_ready, i_bg_color, i_layer_colors,
//                i_layer_alphas
//   Color out  : o_color / o_color_valid / i_color_ready
//   Status     : o_busy
//   modport master : upstream/downstream side (drives the i_* signals)
//   modport slave  : the compositor (drives the o_* signals)
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  logic                      i_pix_valid;
  logic                      o_pix_ready;
  logic [11:0]               i_bg_color;
  logic [12*NUM_LAYERS-1:0]  i_layer_colors;
  logic [3*NUM_LAYERS-1:0]   i_layer_alphas;
  logic [11:0]               o_color;
  logic                      o_color_valid;
  logic                      i_color_ready;
  logic                      o_busy;

  modport master (
    output i_pix_valid, i_bg_color, i_layer_colors, i_layer_alphas, i_color_ready,
    input  o_pix_ready, o_color, o_color_valid, o_busy
  );

  modport slave (
    input  i_pix_valid, i_bg_color, i_layer_colors, i_layer_alphas, i_color_ready,
    output o_pix_ready, o_color, o_color_valid, o_busy
  );
endinterface

// File: rtl/layer_compositor.sv
// layer_compositor
//   Per-pixel compositor: folds NUM_LAYERS foreground layers (layer 0 at the
//   bottom) over a background color with one shared color_blender, one blend
//   per clock, and presents the RGB444 result through a valid/ready port.
//   Ports:
//     i_clk  : system clock, rising edge
//     i_rst  : synchronous active-high reset
//     bus    : layer_compositor_if.slave (job input, color output, busy)
//   Build option:
//     LAYER_COMPOSITOR_SKIP_EN - layers with alpha code 0 take no blend cycle;
//                                the composited color is the same either way.
//
// color_blender
//   Combinational per-channel mix: out = (fg*a + bg*(7-a) + 3) / 7.
//   a=0 returns bg exactly, a=7 returns fg exactly.
//   Ports: bg, fg (RGB444), alpha (3-bit code), blended (RGB444)

module color_blender (
  input  logic [11:0] bg,
  input  logic [11:0] fg,
  input  logic [2:0]  alpha,
  output logic [11:0] blended
);
  logic [6:0] sum;

  always_comb begin
    blended = '0;
    sum     = '0;
    for (int c = 0; c < 3; c++) begin
      sum = 7'(fg[4*c +: 4]) * 7'(alpha)
          + 7'(bg[4*c +: 4]) * (7'd7 - 7'(alpha))
          + 7'd3;
      blended[4*c +: 4] = 4'(sum / 7'd7);
    end
  end
endmodule

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a job; accept captures inputs and seeds acc with bg
// BLEND | one layer folded into acc per cycle, idx walks bottom to top
// DONE  | o_color = final acc, o_color_valid held until i_color_ready
module layer_compositor #(
  parameter int NUM_LAYERS = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  layer_compositor_if.slave bus
);
  localparam int IDXW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLEND,
    DONE
  } state_t;

  state_t                    state;
  logic [12*NUM_LAYERS-1:0]  col_q;
  logic [3*NUM_LAYERS-1:0]   alp_q;
  logic [11:0]               acc;
  logic [IDXW-1:0]           idx;
  logic [11:0]               color_q;
  logic                      valid_q;
  logic                      ready_q;
  logic                      busy_q;

  logic [11:0]               sel_color;
  logic [2:0]                sel_alpha;
  logic [11:0]               blend_out;
  logic                      step_last;
  logic [IDXW-1:0]           step_next;

  always_comb begin
    sel_color = col_q[int'(idx)*12 +: 12];
    sel_alpha = alp_q[int'(idx)*3 +: 3];
  end

  color_blender u_blend (
    .bg      (acc),
    .fg      (sel_color),
    .alpha   (sel_alpha),
    .blended (blend_out)
  );

`ifdef LAYER_COMPOSITOR_SKIP_EN
  logic            first_found;
  logic [IDXW-1:0] first_idx;
  logic            next_found;
  logic [IDXW-1:0] next_idx;

  // Downward scan so the lowest qualifying layer is the one that sticks.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (bus.i_layer_alphas[3*k +: 3] != 3'd0) begin
        first_found = 1'b1;
        first_idx   = IDXW'(k);
      end
      if ((k > int'(idx)) && (alp_q[3*k +: 3] != 3'd0)) begin
        next_found = 1'b1;
        next_idx   = IDXW'(k);
      end
    end
  end

  always_comb begin
    step_last = !next_found;
    step_next = next_idx;
  end
`else
  always_comb begin
    step_last = (idx == LAST_IDX);
    step_next = step_last ? idx : idx + IDXW'(1);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      col_q   <= '0;
      alp_q   <= '0;
      acc     <= '0;
      idx     <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_pix_valid) begin
            col_q   <= bus.i_layer_colors;
            alp_q   <= bus.i_layer_alphas;
            acc     <= bus.i_bg_color;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef LAYER_COMPOSITOR_SKIP_EN
            if (first_found) begin
              idx   <= first_idx;
              state <= BLEND;
            end else begin
              // Nothing visible to fold: background goes straight out.
              idx     <= '0;
              color_q <= bus.i_bg_color;
              valid_q <= 1'b1;
              state   <= DONE;
            end
`else
            idx   <= '0;
            state <= BLEND;
`endif
          end
        end

        BLEND: begin
          acc <= blend_out;
          if (step_last) begin
            color_q <= blend_out;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= step_next;
          end
        end

        DONE: begin
          if (bus.i_color_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_pix_ready   = ready_q;
  assign bus.o_color       = color_q;
  assign bus.o_color_valid = valid_q;
  assign bus.o_busy        = busy_q;
endmodule
